instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/bitblaster_pkg.sv | 63 ++++++
 rtl/dec2to4.sv | 18 +
 rtl/instr_sequencer.sv | 137 +++++++++++++
 tb/tb_instr_sequencer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/bitblaster_pkg.sv
`default_nettype none
// ============================================================================
// Module : bitblaster_pkg
// Brief  : Opcode/timestep enums, ALU codes and instruction field positions
//          shared by the bit-blaster sequencer.
// Rev    : 1.0 initial release
// ============================================================================
package bitblaster_pkg;

    typedef enum logic [3:0] {
        OP_LD  = 4'b0000,
        OP_MOV = 4'b0001,
        OP_ADD = 4'b0010,
        OP_SUB = 4'b0011,
        OP_AND = 4'b0100,
        OP_OR  = 4'b0101,
        OP_XOR = 4'b0110,
        OP_NOT = 4'b0111
    } opcode_e;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } tstep_e;

    localparam logic [3:0] c_alu_add = 4'b0000;
    localparam logic [3:0] c_alu_sub = 4'b0001;
    localparam logic [3:0] c_alu_and = 4'b0010;
    localparam logic [3:0] c_alu_or  = 4'b0011;
    localparam logic [3:0] c_alu_xor = 4'b0100;
    localparam logic [3:0] c_alu_not = 4'b0101;

    localparam int unsigned c_op_hi = 9;
    localparam int unsigned c_op_lo = 6;
    localparam int unsigned c_rx_hi = 5;
    localparam int unsigned c_rx_lo = 4;
    localparam int unsigned c_ry_hi = 3;
    localparam int unsigned c_ry_lo = 2;

    // Two-operand ALU instructions: load A, then G, then write back.
    function automatic logic is_binop(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_OR)  || (op == OP_XOR);
    endfunction

    function automatic logic [3:0] alu_code(input logic [3:0] op);
        logic [3:0] code;
        code = c_alu_add;
        case (op)
            OP_SUB:  code = c_alu_sub;
            OP_AND:  code = c_alu_and;
            OP_OR:   code = c_alu_or;
            OP_XOR:  code = c_alu_xor;
            OP_NOT:  code = c_alu_not;
            default: code = c_alu_add;
        endcase
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dec2to4.sv
`default_nettype none
// ============================================================================
// Module : dec2to4
// Brief  : 2-bit select with enable to one-hot 4-bit decoder.
// Rev    : 1.0 initial release
// ============================================================================
module dec2to4 (
    input  logic [1:0] i_sel,
    input  logic       i_en,
    output logic [3:0] o_onehot
);

    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign o_onehot[i] = i_en && (i_sel == 2'(i));
    end

endmodule
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module : instr_sequencer
// Brief  : T0..T3 control-step sequencer for the bit-blaster datapath.
// Rev    : 1.0 initial release
// ============================================================================
module instr_sequencer
    import bitblaster_pkg::*;
(
    input  logic       CLKb,
    input  logic       Clrb,
    input  logic       Run,
    input  logic [9:0] Instr,
    output logic       IRin,
    output logic       Ext,
    output logic [3:0] Rin,
    output logic [3:0] Rout,
    output logic       Ain,
    output logic       Gin,
    output logic       Gout,
    output logic [3:0] ALUcont,
    output logic       Done,
    output logic [1:0] Tstep
);

    tstep_e     step_q;
    tstep_e     step_d;

    logic [3:0] op;
    logic [1:0] rx;
    logic [1:0] ry;
    logic       rin_en;
    logic [1:0] rin_sel;
    logic       rout_en;
    logic [1:0] rout_sel;
    logic       unused_bits;

    assign op          = Instr[c_op_hi:c_op_lo];
    assign rx          = Instr[c_rx_hi:c_rx_lo];
    assign ry          = Instr[c_ry_hi:c_ry_lo];
    assign unused_bits = ^Instr[1:0];

    always_ff @(posedge CLKb) begin
        if (!Clrb) begin
            step_q <= T0;
        end else begin
            step_q <= step_d;
        end
    end

    always_comb begin
        IRin     = 1'b0;
        Ext      = 1'b0;
        Ain      = 1'b0;
        Gin      = 1'b0;
        Gout     = 1'b0;
        ALUcont  = c_alu_add;
        Done     = 1'b0;
        rin_en   = 1'b0;
        rin_sel  = rx;
        rout_en  = 1'b0;
        rout_sel = rx;

        // Instr is still being loaded during T0, so only Run matters here.
        case (step_q)
            T0: begin
                IRin = Run;
            end
            T1: begin
                if (op == OP_LD) begin
                    Ext    = 1'b1;
                    rin_en = 1'b1;
                    Done   = 1'b1;
                end else if (op == OP_MOV) begin
                    rout_en  = 1'b1;
                    rout_sel = ry;
                    rin_en   = 1'b1;
                    Done     = 1'b1;
                end else if (is_binop(op)) begin
                    rout_en = 1'b1;
                    Ain     = 1'b1;
                end else if (op == OP_NOT) begin
                    rout_en = 1'b1;
                    Gin     = 1'b1;
                    ALUcont = alu_code(op);
                end else begin
                    Done = 1'b1;
                end
            end
            T2: begin
                if (is_binop(op)) begin
                    rout_en  = 1'b1;
                    rout_sel = ry;
                    Gin      = 1'b1;
                    ALUcont  = alu_code(op);
                end else if (op == OP_NOT) begin
                    Gout   = 1'b1;
                    rin_en = 1'b1;
                    Done   = 1'b1;
                end
            end
            T3: begin
                if (is_binop(op)) begin
                    Gout   = 1'b1;
                    rin_en = 1'b1;
                    Done   = 1'b1;
                end
            end
            default: ;
        endcase

        step_d = step_q;
        if (step_q == T0) begin
            step_d = Run ? T1 : T0;
        end else if (Done) begin
            step_d = T0;
        end else begin
            step_d = tstep_e'(step_q + 2'd1);
        end
    end

    dec2to4 u_rin_dec (
        .i_sel    (rin_sel),
        .i_en     (rin_en),
        .o_onehot (Rin)
    );

    dec2to4 u_rout_dec (
        .i_sel    (rout_sel),
        .i_en     (rout_en),
        .o_onehot (Rout)
    );

    assign Tstep = step_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_instr_sequencer
// Brief  : Scoreboard bench: driver queues per-cycle expected controls,
//          monitor compares on the falling edge.
// Rev    : 1.0 initial release
// ============================================================================
module tb_instr_sequencer;

    typedef struct packed {
        logic       irin;
        logic       ext;
        logic [3:0] rin;
        logic [3:0] rout;
        logic       ain;
        logic       gin;
        logic       gout;
        logic [3:0] alu;
        logic       done;
        logic [1:0] ts;
    } exp_t;

    logic       CLKb = 1'b0;
    logic       Clrb;
    logic       Run;
    logic [9:0] Instr;
    logic       IRin, Ext, Ain, Gin, Gout, Done;
    logic [3:0] Rin, Rout, ALUcont;
    logic [1:0] Tstep;

    exp_t  exp_q[$];
    string name_q[$];
    int    vectors     = 0;
    int    miscompares = 0;
    logic  checks_on   = 1'b0;

    always #5 CLKb = ~CLKb;

    instr_sequencer u_dut (
        .CLKb    (CLKb),
        .Clrb    (Clrb),
        .Run     (Run),
        .Instr   (Instr),
        .IRin    (IRin),
        .Ext     (Ext),
        .Rin     (Rin),
        .Rout    (Rout),
        .Ain     (Ain),
        .Gin     (Gin),
        .Gout    (Gout),
        .ALUcont (ALUcont),
        .Done    (Done),
        .Tstep   (Tstep)
    );

    function automatic exp_t mk(input logic irin, input logic ext,
                                input logic [3:0] rin, input logic [3:0] rout,
                                input logic ain, input logic gin, input logic gout,
                                input logic [3:0] alu, input logic done,
                                input logic [1:0] ts);
        exp_t e;
        e = '{irin, ext, rin, rout, ain, gin, gout, alu, done, ts};
        return e;
    endfunction

    always @(negedge CLKb) begin
        exp_t act;
        exp_t e;
        string nm;
        act = '{IRin, Ext, Rin, Rout, Ain, Gin, Gout, ALUcont, Done, Tstep};
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            vectors++;
            if (act !== e) begin
                miscompares++;
                $display("FAIL %s: got %06h (irin ext rin rout ain gin gout alu done ts) expected %06h",
                         nm, act, e);
            end
        end
        if (checks_on) begin
            vectors++;
            if ($countones({Ext, Rout, Gout}) > 1) begin
                miscompares++;
                $display("FAIL bus_exclusive: Ext=%b Rout=%b Gout=%b required at most one driver",
                         Ext, Rout, Gout);
            end
            vectors++;
            if (!Gin && ALUcont != 4'b0000) begin
                miscompares++;
                $display("FAIL alucont_idle: ALUcont=%b with Gin=0, required 0000", ALUcont);
            end
        end
    end

    task automatic cyc(input logic run, input logic clrb, input exp_t e, input string nm);
        @(posedge CLKb);
        #1;
        Run  = run;
        Clrb = clrb;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // IR loads on the falling edge of T0; garbage before then must not matter.
    task automatic fetch(input logic [9:0] instr, input string nm);
        cyc(1'b1, 1'b1, mk(1, 0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0, 2'd0), nm);
        Instr = ~instr;
        #5;
        Instr = instr;
    endtask

    task automatic idle(input string nm);
        cyc(1'b0, 1'b1, mk(0, 0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0, 2'd0), nm);
    endtask

    logic [9:0] alu_instr [5] = '{10'h098, 10'h0E8, 10'h104, 10'h15C, 10'h1B0};
    logic [3:0] alu_rx    [5] = '{4'b0010, 4'b0100, 4'b0001, 4'b0010, 4'b1000};
    logic [3:0] alu_ry    [5] = '{4'b0100, 4'b0100, 4'b0010, 4'b1000, 4'b0001};
    logic [3:0] alu_code  [5] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100};

    initial begin
        Clrb  = 1'b0;
        Run   = 1'b0;
        Instr = 10'h000;
        repeat (2) @(posedge CLKb);
        #1;
        checks_on = 1'b1;
        cyc(1'b0, 1'b0, mk(0, 0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0, 2'd0), "reset_t0");

        fetch(10'h030, "ld_t0");
        cyc(1'b1, 1'b1, mk(0, 1, 4'b1000, 4'h0, 0, 0, 0, 4'h0, 1, 2'd1), "ld_t1");
        idle("ld_back_t0");

        for (int i = 0; i < 5; i++) begin
            fetch(alu_instr[i], "alu_t0");
            cyc(1'b1, 1'b1, mk(0, 0, 4'h0, alu_rx[i], 1, 0, 0, 4'h0, 0, 2'd1), "alu_t1");
            cyc(1'b0, 1'b1, mk(0, 0, 4'h0, alu_ry[i], 0, 1, 0, alu_code[i], 0, 2'd2), "alu_t2");
            cyc(1'b1, 1'b1, mk(0, 0, alu_rx[i], 4'h0, 0, 0, 1, 4'h0, 1, 2'd3), "alu_t3");
        end
        idle("alu_back_t0");

        fetch(10'h04C, "mov_t0");
        cyc(1'b0, 1'b1, mk(0, 0, 4'b0001, 4'b1000, 0, 0, 0, 4'h0, 1, 2'd1), "mov_t1");
        idle("mov_back_t0");

        fetch(10'h1E0, "not_t0");
        cyc(1'b0, 1'b1, mk(0, 0, 4'h0, 4'b0100, 0, 1, 0, 4'b0101, 0, 2'd1), "not_t1");
        cyc(1'b0, 1'b1, mk(0, 0, 4'b0100, 4'h0, 0, 0, 1, 4'h0, 1, 2'd2), "not_t2");

        fetch(10'h3C0, "rsv_t0");
        cyc(1'b0, 1'b1, mk(0, 0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 1, 2'd1), "rsv_t1");
        for (int i = 0; i < 5; i++) idle("hold_t0");

        fetch(10'h098, "abort_t0");
        cyc(1'b1, 1'b1, mk(0, 0, 4'h0, 4'b0010, 1, 0, 0, 4'h0, 0, 2'd1), "abort_t1");
        cyc(1'b1, 1'b0, mk(0, 0, 4'h0, 4'b0100, 0, 1, 0, 4'h0, 0, 2'd2), "abort_t2");
        idle("abort_after_rst");
        idle("abort_idle");

        // Reset beats a Run request sampled in T0.
        cyc(1'b1, 1'b0, mk(1, 0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0, 2'd0), "rst_vs_run_t0");
        idle("rst_vs_run_hold");

        fetch(10'h030, "ld2_t0");
        cyc(1'b0, 1'b1, mk(0, 1, 4'b1000, 4'h0, 0, 0, 0, 4'h0, 1, 2'd1), "ld2_t1");
        idle("ld2_back_t0");

        @(posedge CLKb);
        @(negedge CLKb);
        #1;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL queue_drain: %0d entries left, required 0", exp_q.size());
        end
        checks_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
